// File: rtl/rv_tcm_port_pkg.sv
// rv_tcm_port_pkg: load funct3 encodings, port state type and the slave-select
// address map shared with the memory stage.
`ifndef SLAVE_SEL_FROM
`define SLAVE_SEL_FROM 31
`endif
`ifndef SLAVE_SEL_TO
`define SLAVE_SEL_TO 28
`endif
`ifndef TCM_ADDR_SEL
`define TCM_ADDR_SEL 4'h2
`endif

package rv_tcm_port_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {ST_CLEAR, ST_READY} tcm_state_t;
endpackage

// File: rtl/rv_load_align.sv
// rv_load_align: combinational load extraction (byte/halfword select plus
// sign/zero extension) from a raw word, byte offset and funct3.
module rv_load_align
    import rv_tcm_port_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = i_word[{i_off, 3'b000} +: 8];
    assign h = i_off[1] ? i_word[31:16] : i_word[15:0];

    assign o_data = (i_funct3 == F3_LB)  ? {{24{b[7]}}, b} :
                    (i_funct3 == F3_LBU) ? {24'b0, b} :
                    (i_funct3 == F3_LH)  ? {{16{h[15]}}, h} :
                    (i_funct3 == F3_LHU) ? {16'b0, h} : i_word;
endmodule

// File: rtl/rv_tcm_port.sv
// rv_tcm_port: tightly-coupled data RAM responder with byte-masked stores and
// 1-cycle aligned loads. Define RV_TCM_CLEAR_EN to zero-fill the RAM after reset.
module rv_tcm_port
    import rv_tcm_port_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_addr,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [3:0]  i_mem_sel,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic        o_hit,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_stall
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    tcm_state_t            state_q, state_d;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           word_q;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  accept, wr_en, rd_en;
    logic                  unused_addr;

    assign o_hit  = i_addr[`SLAVE_SEL_FROM:`SLAVE_SEL_TO] == `TCM_ADDR_SEL;
    assign idx    = i_addr[ADDR_WIDTH+1:2];
    assign accept = (state_q == ST_READY) && o_hit;
    assign wr_en  = accept && i_mem_write;
    // a read that collides with a write is dropped: the write wins
    assign rd_en  = accept && i_mem_read && !i_mem_write;
    assign unused_addr = ^i_addr[`SLAVE_SEL_TO-1:ADDR_WIDTH+2];

`ifdef RV_TCM_CLEAR_EN
    localparam tcm_state_t RST_STATE = ST_CLEAR;
    logic [ADDR_WIDTH-1:0] clr_q, clr_d;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == ST_CLEAR) begin
            clr_d = clr_q + 1'b1;
            if (&clr_q) state_d = ST_READY;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) clr_q <= '0;
        else            clr_q <= clr_d;
    end

    assign o_stall = state_q == ST_CLEAR;
`else
    localparam tcm_state_t RST_STATE = ST_READY;

    always_comb begin
        state_d = ST_READY;
    end

    assign o_stall = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= RST_STATE;
        else            state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
`ifdef RV_TCM_CLEAR_EN
        if (state_q == ST_CLEAR) mem[clr_q] <= '0;
        else
`endif
        if (wr_en) begin
            for (int k = 0; k < 4; k++)
                if (i_mem_sel[k]) mem[idx][8*k +: 8] <= i_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            word_q  <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) begin
                word_q <= mem[idx];
                off_q  <= i_addr[1:0];
                f3_q   <= i_funct3;
            end
        end
    end

    assign o_rdata_valid = valid_q;

    rv_load_align u_align (
        .i_word  (word_q),
        .i_off   (off_q),
        .i_funct3(f3_q),
        .o_data  (o_rdata)
    );
endmodule

// File: doc/rv_tcm_port.md
Name: rv_tcm_port

Overview:
- Responder end of the data-memory interface driven by the pipeline's memory stage.
- Decodes TCM hits and performs byte-masked stores into an internal synchronous word RAM.
- Returns load data one cycle later, aligned and sign/zero-extended per funct3, ready for writeback.
- Optionally zero-fills the RAM after reset, stalling the pipeline while it does so.

Parameters:
- ADDR_WIDTH, 12: word-address bits. Depth is 2**ADDR_WIDTH words (default 16 KiB).

Ports:
- i_clk  in  1  : single clock; all state on rising edge.
- i_reset_n  in  1  : asynchronous, active-low reset.
- i_addr  in  32  : byte address (memory-stage ALU result).
- i_mem_read  in  1  : load request.
- i_mem_write  in  1  : store request.
- i_mem_sel  in  4  : byte-lane enables, already decoded from funct3 and addr[1:0].
- i_wdata  in  32  : store data, already lane-replicated.
- i_funct3  in  3  : access size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- o_hit  out  1  : combinational; addr[`SLAVE_SEL_FROM:`SLAVE_SEL_TO] == `TCM_ADDR_SEL.
- o_rdata  out  32  : aligned, extended load result.
- o_rdata_valid  out  1  : one-cycle pulse for each accepted load.
- o_stall  out  1  : high while the port cannot accept requests.

Behaviour:
- Reset values: o_rdata = 0, o_rdata_valid = 0, captured addr[1:0]/funct3 = 0. State goes to ST_CLEAR if the feature is enabled, else ST_READY.
- Word index: addr[ADDR_WIDTH+1:2]. Address bits between ADDR_WIDTH+2 and the slave-select field are ignored, so the RAM aliases across that range.
- Accept rule: a request is accepted only when state == ST_READY and o_hit == 1. Requests are ignored in any other state or on a miss, with no response.
- Store: on the accepting edge, write each byte lane k where i_mem_sel[k] = 1 with i_wdata[8k+7:8k]. Other lanes are unchanged. No response is generated.
- Load: on the accepting edge, read the RAM word and capture addr[1:0] and funct3. In the following cycle, o_rdata_valid = 1 and o_rdata = extracted value. Latency is exactly 1.
- Extraction (selected byte = captured addr[1:0]):
  - LB / LBU: select the byte, sign-extend / zero-extend.
  - LH / LHU: select the halfword at addr[1], sign-extend / zero-extend.
  - LW and any other funct3: return the whole word.
- o_rdata holds its value until the next load response and does not return to 0.
- Simultaneous read and write (illegal from the pipeline): the write is performed and no read response is produced.
- Back-to-back: a store at cycle N followed by a load of the same word at N+1 returns the new data. Loads may be issued every cycle, giving one response per cycle.
- o_stall = 1 iff state == ST_CLEAR.
- FSM (feature enabled):
  - ST_CLEAR: counter starts at 0 and writes one zero word per cycle. After the word at the last index (2**ADDR_WIDTH − 1) is written, go to ST_READY.
  - ST_READY is terminal until reset.
  - Reset asserted mid-clear restarts the counter at 0.

Optional Feature:
- RV_TCM_CLEAR_EN defined: ST_CLEAR zero-fill runs after every reset. Takes 2**ADDR_WIDTH cycles with o_stall = 1.
- Not defined: no clear counter. The port leaves reset directly in ST_READY, o_stall is tied 0, and RAM contents are undefined.

Decomposition:
- Shared defines/package:
  - load funct3 encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - state enum typedef tcm_state_t {ST_CLEAR, ST_READY};
  - `SLAVE_SEL_FROM / `SLAVE_SEL_TO / `TCM_ADDR_SEL, already shared with the memory stage.
- One natural sub-module: rv_load_align, purely combinational extraction from {word, addr[1:0], funct3}. It is reusable by other slaves' read paths.

Test Plan:
- Reset with RV_TCM_CLEAR_EN, ADDR_WIDTH = 4 -> o_stall high for exactly 16 cycles, then low; LW of word 5 -> 0x00000000.
- SW 0x80FF7F01 to word 3, then LB at offsets 0/1/2/3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. LBU at offset 3 -> 0x00000080.
- SH 0xBEEF (sel 4'b1100) to word 2 holding 0x11223344, then LW -> 0xBEEF3344. LH at addr[1] = 1 -> 0xFFFFBEEF. LHU -> 0x0000BEEF.
- Store at cycle N, LW of the same word at N+1 -> new data with o_rdata_valid exactly at N+2. Three consecutive LWs -> three consecutive valid pulses.
- Request with the select field ≠ `TCM_ADDR_SEL -> o_hit = 0, no RAM change, no o_rdata_valid. Request during ST_CLEAR -> ignored.
- Deassert then reassert i_reset_n mid-clear -> o_stall remains high a full 16 cycles after release, and o_rdata = 0 from reset until the first load.
